// File: rtl/rand_mem_read_module_if.sv
// ============================================================================
// Module      : rand_mem_read_module_if
// Description : Request, memory-read and response signal bundle for
//               rand_mem_read_module.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rand_mem_read_module_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int SIDE_WIDTH = 8
);
    logic [SIDE_WIDTH+ADDR_WIDTH-1:0] data_i;
    logic                             valid_i;
    logic                             ready_o;
    logic                             mem_read;
    logic [ADDR_WIDTH-1:0]            mem_addr;
    logic [DATA_WIDTH-1:0]            mem_rdata;
    logic                             mem_resp;
    logic [SIDE_WIDTH+DATA_WIDTH-1:0] data_o;
    logic                             err_o;
    logic                             valid_o;
    logic                             ready_i;
    logic                             done;

    modport master (
        output data_i, valid_i, mem_rdata, mem_resp, ready_i,
        input  ready_o, mem_read, mem_addr, data_o, err_o, valid_o, done
    );

    modport slave (
        input  data_i, valid_i, mem_rdata, mem_resp, ready_i,
        output ready_o, mem_read, mem_addr, data_o, err_o, valid_o, done
    );
endinterface

`default_nettype wire

// File: rtl/rand_mem_read_module.sv
// ============================================================================
// Module      : rand_mem_read_module
// Description : Single-outstanding memory read initiator with optional
//               response timeout and a 2-entry output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rand_mem_read_module #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int SIDE_WIDTH     = 8,
    parameter int INPUT_WIDTH    = SIDE_WIDTH + ADDR_WIDTH,
    parameter int OUTPUT_WIDTH   = SIDE_WIDTH + DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    rand_mem_read_module_if.slave  bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    localparam int c_TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST =
        (TIMEOUT_CYCLES > 0) ? c_TIMER_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit c_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [INPUT_WIDTH-1:0]  r_req;
    logic [c_TIMER_W-1:0]    r_timer;

    logic                    w_ready;
    logic                    w_accept;
    logic                    w_push;
    logic                    w_push_err;
    logic [DATA_WIDTH-1:0]   w_push_rdata;
    logic [OUTPUT_WIDTH-1:0] w_push_data;
    logic                    w_pop;

    logic [OUTPUT_WIDTH-1:0] r_fifo_data [2];
    logic                    r_fifo_err  [2];
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [1:0]              r_count;

    // Only one read is ever in flight, so count<2 at accept reserves its slot.
    assign w_ready  = (r_state == S_IDLE) && (r_count != 2'd2) && !rst;
    assign w_accept = bus.valid_i && w_ready;
    assign w_pop    = (r_count != 2'd0) && bus.ready_i;

    always_comb begin
        w_state_nxt  = r_state;
        w_push       = 1'b0;
        w_push_err   = 1'b0;
        w_push_rdata = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_resp) begin
                    w_push       = 1'b1;
                    w_push_rdata = bus.mem_rdata;
                    w_state_nxt  = S_IDLE;
                end else if (c_TIMEOUT_EN && (r_timer == c_TIMER_LAST)) begin
                    w_push      = 1'b1;
                    w_push_err  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_push_data = {r_req[INPUT_WIDTH-1 -: SIDE_WIDTH], w_push_rdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_req   <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_req   <= bus.data_i;
                r_timer <= '0;
            end else if (r_state == S_REQ) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_err[0]  <= 1'b0;
            r_fifo_err[1]  <= 1'b0;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_count        <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= w_push_data;
                r_fifo_err[r_wr_ptr]  <= w_push_err;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.ready_o  = w_ready;
    assign bus.mem_read = (r_state == S_REQ);
    assign bus.mem_addr = r_req[ADDR_WIDTH-1:0];
    assign bus.data_o   = r_fifo_data[r_rd_ptr];
    assign bus.err_o    = r_fifo_err[r_rd_ptr];
    assign bus.valid_o  = (r_count != 2'd0);
    assign bus.done     = (r_state == S_IDLE) && (r_count == 2'd0);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && (r_count == 2'd2)));

endmodule

`default_nettype wire
